// File: rtl/debounce_pkg.sv
// Shared types and default timing for the pushbutton conditioner.
// Defaults assume the 50 MHz board clock.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_L2H  = 2'd1,
        ST_HIGH = 2'd2,
        ST_H2L  = 2'd3
    } db_state_t;

    localparam int DB_PRESS_CLKS_DEF    = 20;
    localparam int DB_RELEASE_CLKS_DEF  = 50;
    localparam int DB_PULSE_CLKS_DEF    = 96;
    localparam int DB_REPEAT_DELAY_DEF  = 25_000_000;
    localparam int DB_REPEAT_PERIOD_DEF = 5_000_000;

    // True when a timing value is non-zero and representable in a width-bit counter.
    function automatic bit db_param_ok(input int value, input int width);
        return (value >= 1) && ((width >= 31) || (value < (1 << width)));
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, press/release qualification FSM,
// one-shot pulse stretcher and optional typematic repeat.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_W         = 25,
    parameter int PRESS_CLKS    = DB_PRESS_CLKS_DEF,
    parameter int RELEASE_CLKS  = DB_RELEASE_CLKS_DEF,
    parameter int PULSE_CLKS    = DB_PULSE_CLKS_DEF,
    parameter int PRESS_MODE    = 1,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = DB_REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = DB_REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic db_level,
    output logic pulse,
    output logic pulse_next
);

    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CLKS - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CLKS - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CLKS);
    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam bit               REPEAT_ON    = (REPEAT_EN != 0) && (PRESS_MODE != 0);
    localparam bit               ON_PRESS     = (PRESS_MODE != 0);

    logic             sync1_q, sync2_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             rep_phase_q, rep_phase_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    logic             s;
    logic             rise_evt, fall_evt, rep_evt, trig, in_held;
    logic [CNT_W-1:0] rep_last;

    assign s = sync2_q;

    // NOTE: every signal gets a default at the top of the block, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_evt = 1'b0;
        fall_evt = 1'b0;

        unique case (state_q)
            ST_LOW: begin
                cnt_d = CNT_ZERO;
                if (s) begin
                    if (PRESS_LAST == CNT_ZERO) begin
                        state_d  = ST_HIGH;
                        level_d  = 1'b1;
                        rise_evt = 1'b1;
                    end else begin
                        state_d = ST_L2H;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_L2H: begin
                if (!s) begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == PRESS_LAST) begin
                    state_d  = ST_HIGH;
                    cnt_d    = CNT_ZERO;
                    level_d  = 1'b1;
                    rise_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                cnt_d = CNT_ZERO;
                if (!s) begin
                    if (RELEASE_LAST == CNT_ZERO) begin
                        state_d  = ST_LOW;
                        level_d  = 1'b0;
                        fall_evt = 1'b1;
                    end else begin
                        state_d = ST_H2L;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_H2L: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == RELEASE_LAST) begin
                    state_d  = ST_LOW;
                    cnt_d    = CNT_ZERO;
                    level_d  = 1'b0;
                    fall_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = CNT_ZERO;
                level_d = 1'b0;
            end
        endcase
    end

    // Repeat timer runs through release bounces; it restarts only from ST_LOW.
    always_comb begin
        rcnt_d      = rcnt_q;
        rep_phase_d = rep_phase_q;
        in_held     = (state_q == ST_HIGH) || (state_q == ST_H2L);
        rep_last    = rep_phase_q ? PERIOD_LAST : DELAY_LAST;
        rep_evt     = REPEAT_ON && in_held && !fall_evt && (rcnt_q == rep_last);

        if (!REPEAT_ON || !in_held || fall_evt) begin
            rcnt_d      = CNT_ZERO;
            rep_phase_d = 1'b0;
        end else if (rep_evt) begin
            rcnt_d      = CNT_ZERO;
            rep_phase_d = 1'b1;
        end else begin
            rcnt_d = rcnt_q + CNT_ONE;
        end
    end

    always_comb begin
        trig   = (ON_PRESS ? rise_evt : fall_evt) || rep_evt;
        pcnt_d = pcnt_q;
        if (trig) begin
            pcnt_d = PULSE_LOAD;
        end else if (pcnt_q != CNT_ZERO) begin
            pcnt_d = pcnt_q - CNT_ONE;
        end
        pulse_d = (pcnt_d != CNT_ZERO);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= ST_LOW;
            cnt_q       <= CNT_ZERO;
            rcnt_q      <= CNT_ZERO;
            rep_phase_q <= 1'b0;
            pcnt_q      <= CNT_ZERO;
            level_q     <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            rep_phase_q <= rep_phase_d;
            pcnt_q      <= pcnt_d;
            level_q     <= level_d;
            pulse_q     <= pulse_d;
        end
    end

    assign db_level   = level_q;
    assign pulse      = pulse_q;
    assign pulse_next = pulse_d;

endmodule

// File: rtl/debounce_multi_repeat.sv
// N-channel pushbutton conditioner for the OTTER MMIO input port: debounced
// levels, per-channel pulses and a registered OR of all pulses.
module debounce_multi_repeat
    import debounce_pkg::*;
#(
    parameter int N_CH          = 5,
    parameter int CNT_W         = 25,
    parameter int PRESS_CLKS    = DB_PRESS_CLKS_DEF,
    parameter int RELEASE_CLKS  = DB_RELEASE_CLKS_DEF,
    parameter int PULSE_CLKS    = DB_PULSE_CLKS_DEF,
    parameter int PRESS_MODE    = 1,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = DB_REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = DB_REPEAT_PERIOD_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] BTN,
    output logic [N_CH-1:0] DB_LEVEL,
    output logic [N_CH-1:0] PULSE,
    output logic            ANY_PULSE
);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
        $error("debounce_multi_repeat: N_CH=%0d outside 1..16", N_CH);
    end
    if (!db_param_ok(PRESS_CLKS, CNT_W) || !db_param_ok(RELEASE_CLKS, CNT_W) ||
        !db_param_ok(PULSE_CLKS, CNT_W)) begin : g_bad_clks
        $error("debounce_multi_repeat: *_CLKS must be >=1 and fit in CNT_W=%0d", CNT_W);
    end
    if (!db_param_ok(REPEAT_DELAY, CNT_W) || !db_param_ok(REPEAT_PERIOD, CNT_W)) begin : g_bad_rep
        $error("debounce_multi_repeat: REPEAT_* must be >=1 and fit in CNT_W=%0d", CNT_W);
    end

    logic [N_CH-1:0] pulse_next;
    logic            any_pulse_q, any_pulse_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .CNT_W         (CNT_W),
            .PRESS_CLKS    (PRESS_CLKS),
            .RELEASE_CLKS  (RELEASE_CLKS),
            .PULSE_CLKS    (PULSE_CLKS),
            .PRESS_MODE    (PRESS_MODE),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk        (CLK),
            .rst        (RST),
            .btn        (BTN[i]),
            .db_level   (DB_LEVEL[i]),
            .pulse      (PULSE[i]),
            .pulse_next (pulse_next[i])
        );
    end

    // Reduce the channels' next-state pulses so ANY_PULSE lands on the same edge as PULSE.
    always_comb begin
        any_pulse_d = |pulse_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            any_pulse_q <= 1'b0;
        end else begin
            any_pulse_q <= any_pulse_d;
        end
    end

    assign ANY_PULSE = any_pulse_q;

endmodule

// File: tb/tb_debounce_multi_repeat.sv
// Directed bench for debounce_multi_repeat: press, release and repeat variants
// share the clock, reset and button stimulus.
module tb_debounce_multi_repeat;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] db_p, pulse_p, db_r, pulse_r, db_a, pulse_a;
    logic         any_p, any_r, any_a;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    debounce_multi_repeat #(
        .N_CH(N), .CNT_W(8), .PRESS_CLKS(4), .RELEASE_CLKS(6), .PULSE_CLKS(3),
        .PRESS_MODE(1), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut_p (
        .CLK(clk), .RST(rst), .BTN(btn), .DB_LEVEL(db_p), .PULSE(pulse_p), .ANY_PULSE(any_p)
    );

    debounce_multi_repeat #(
        .N_CH(N), .CNT_W(8), .PRESS_CLKS(4), .RELEASE_CLKS(6), .PULSE_CLKS(3),
        .PRESS_MODE(0), .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut_r (
        .CLK(clk), .RST(rst), .BTN(btn), .DB_LEVEL(db_r), .PULSE(pulse_r), .ANY_PULSE(any_r)
    );

    debounce_multi_repeat #(
        .N_CH(N), .CNT_W(8), .PRESS_CLKS(4), .RELEASE_CLKS(6), .PULSE_CLKS(3),
        .PRESS_MODE(1), .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut_a (
        .CLK(clk), .RST(rst), .BTN(btn), .DB_LEVEL(db_a), .PULSE(pulse_a), .ANY_PULSE(any_a)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        btn = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Repeat channel: pulse edges at 6, 26, 34, 42, ... ; DB_LEVEL falls at 68.
    function automatic logic rep_pulse(input int e);
        if (e >= 6 && e <= 8) return 1'b1;
        if (e >= 26 && e <= 68) return ((e - 26) % 8) <= 2;
        return 1'b0;
    endfunction

    initial begin
        logic hi, ph;
        rst = 1'b1;
        btn = '0;
        step();
        step();
        check("rst db_p", {28'd0, db_p}, 32'd0);
        check("rst pulse_p", {28'd0, pulse_p}, 32'd0);
        check("rst any_p", {31'd0, any_p}, 32'd0);
        check("rst db_r", {28'd0, db_r}, 32'd0);
        check("rst pulse_a", {28'd0, pulse_a}, 32'd0);
        check("rst any_a", {31'd0, any_a}, 32'd0);
        rst = 1'b0;
        idle(3);

        // Clean press on channel 0.
        for (int e = 1; e <= 40; e++) begin
            btn = (e <= 30) ? 4'b0001 : 4'b0000;
            step();
            hi = (e >= 6 && e < 38);
            ph = (e >= 6 && e <= 8);
            check($sformatf("clean db e%0d", e), {28'd0, db_p}, {28'd0, 3'b000, hi});
            check($sformatf("clean pulse e%0d", e), {28'd0, pulse_p}, {28'd0, 3'b000, ph});
            check($sformatf("clean any e%0d", e), {31'd0, any_p}, {31'd0, ph});
        end
        idle(15);

        // Bounce on channel 1: high 3, low 1, high 20.
        for (int e = 1; e <= 40; e++) begin
            btn = ((e <= 3) || (e >= 5 && e <= 24)) ? 4'b0010 : 4'b0000;
            step();
            hi = (e >= 10 && e < 32);
            ph = (e >= 10 && e <= 12);
            check($sformatf("bounce db e%0d", e), {28'd0, db_p}, {28'd0, 2'b00, hi, 1'b0});
            check($sformatf("bounce pulse e%0d", e), {28'd0, pulse_p}, {28'd0, 2'b00, ph, 1'b0});
            check($sformatf("bounce any e%0d", e), {31'd0, any_p}, {31'd0, ph});
        end
        idle(15);

        // Release mode, channel 0: 10 high, 3 low, 2 high glitch, then low.
        for (int e = 1; e <= 35; e++) begin
            btn = ((e <= 10) || e == 14 || e == 15) ? 4'b0001 : 4'b0000;
            step();
            hi = (e >= 6 && e < 23);
            ph = (e >= 23 && e <= 25);
            check($sformatf("relmode db e%0d", e), {28'd0, db_r}, {28'd0, 3'b000, hi});
            check($sformatf("relmode pulse e%0d", e), {28'd0, pulse_r}, {28'd0, 3'b000, ph});
            check($sformatf("relmode any e%0d", e), {31'd0, any_r}, {31'd0, ph});
        end
        idle(15);

        // Auto-repeat on channel 2 held 60 cycles; the non-repeat variant pulses once.
        for (int e = 1; e <= 80; e++) begin
            btn = (e <= 60) ? 4'b0100 : 4'b0000;
            step();
            hi = (e >= 6 && e < 68);
            ph = rep_pulse(e);
            check($sformatf("rep db e%0d", e), {28'd0, db_a}, {28'd0, 1'b0, hi, 2'b00});
            check($sformatf("rep pulse e%0d", e), {28'd0, pulse_a}, {28'd0, 1'b0, ph, 2'b00});
            check($sformatf("rep any e%0d", e), {31'd0, any_a}, {31'd0, ph});
            check($sformatf("norep pulse e%0d", e), {28'd0, pulse_p},
                  {28'd0, 1'b0, (e >= 6 && e <= 8), 2'b00});
        end
        idle(15);

        // Reset while held with PULSE high; the held button must requalify.
        btn = 4'b0001;
        for (int e = 1; e <= 7; e++) step();
        check("midrst pre pulse", {28'd0, pulse_p}, 32'd1);
        check("midrst pre db", {28'd0, db_p}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst async db", {28'd0, db_p}, 32'd0);
        check("midrst async pulse", {28'd0, pulse_p}, 32'd0);
        check("midrst async any", {31'd0, any_p}, 32'd0);
        step();
        step();
        check("midrst held pulse", {28'd0, pulse_p}, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            hi = (k >= 6);
            ph = (k >= 6 && k <= 8);
            check($sformatf("midrst db k%0d", k), {28'd0, db_p}, {28'd0, 3'b000, hi});
            check($sformatf("midrst pulse k%0d", k), {28'd0, pulse_p}, {28'd0, 3'b000, ph});
            check($sformatf("midrst any k%0d", k), {31'd0, any_p}, {31'd0, ph});
        end
        idle(15);

        // Simultaneous press on channels 2 and 3.
        for (int e = 1; e <= 30; e++) begin
            btn = (e <= 15) ? 4'b1100 : 4'b0000;
            step();
            hi = (e >= 6 && e < 23);
            ph = (e >= 6 && e <= 8);
            check($sformatf("simul db e%0d", e), {28'd0, db_p}, {28'd0, hi, hi, 2'b00});
            check($sformatf("simul pulse e%0d", e), {28'd0, pulse_p}, {28'd0, ph, ph, 2'b00});
            check($sformatf("simul any e%0d", e), {31'd0, any_p}, {31'd0, ph});
        end
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
